// File: rtl/lc3_regfile_banked.sv
// lc3_regfile_banked: parametrised LC-3 register file with two combinational read ports,
// optional write bypass and a hardware user/supervisor stack-pointer bank swap.
module lc3_regfile_banked #(
    parameter int              DW       = 16,
    parameter int              NREG     = 8,
    parameter int              AW       = 3,
    parameter int              SP_IDX   = 6,
    parameter logic [DW-1:0]   SSP_INIT = 16'h3000,
    parameter bit              BYPASS   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd1_addr,
    input  logic [AW-1:0] rd2_addr,
    output logic [DW-1:0] rd1_data,
    output logic [DW-1:0] rd2_data,
    input  logic          sp_swap_req,
    input  logic          sp_swap_to_super,
    output logic          sp_swap_busy,
    output logic          sp_swap_done,
    output logic          priv,
    output logic          wr_conflict
);
    typedef enum logic [1:0] {IDLE, SAVE, LOAD} state_t;
    localparam logic [AW-1:0] SP = AW'(SP_IDX);
    state_t        state, state_nxt;
    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] usp_shadow, ssp_shadow;
    logic          target, done_q, conflict_q, wr_drop, wr_ok;
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    always_comb begin
        state_nxt = (state == IDLE) ? ((sp_swap_req && sp_swap_to_super != priv) ? SAVE : IDLE)
                  : (state == SAVE) ? LOAD : IDLE;
    end
    always_comb begin
        sp_swap_busy = state != IDLE;
        sp_swap_done = done_q;
        wr_conflict  = conflict_q;
        wr_drop      = wr_en && wr_addr == SP && state != IDLE;
        wr_ok        = wr_en && !wr_drop;
    end
    // Only writes that actually land are forwarded; the internal LOAD write never is.
    assign rd1_data = (BYPASS && wr_ok && wr_addr == rd1_addr) ? wr_data : regs[rd1_addr];
    assign rd2_data = (BYPASS && wr_ok && wr_addr == rd2_addr) ? wr_data : regs[rd2_addr];
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            usp_shadow <= '0;
            ssp_shadow <= SSP_INIT;
            priv       <= 1'b0;
            target     <= 1'b0;
            done_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            if (wr_ok) regs[wr_addr] <= wr_data;
            if (state == IDLE && state_nxt == SAVE) target <= sp_swap_to_super;
            if (state == SAVE) begin
                if (priv) ssp_shadow <= regs[SP];
                else      usp_shadow <= regs[SP];
            end
            if (state == LOAD) begin
                regs[SP] <= target ? ssp_shadow : usp_shadow;
                priv     <= target;
            end
            done_q     <= state == LOAD;
            conflict_q <= wr_drop;
        end
endmodule

// File: tb/tb_lc3_regfile_banked.sv
// tb_lc3_regfile_banked: scoreboard-driven checks of reads, bypass, SP bank swaps and reset.
module tb_lc3_regfile_banked;
    logic        clk = 0, rst = 0, wr_en = 0, sp_swap_req = 0, sp_swap_to_super = 0;
    logic [2:0]  wr_addr = 0, rd1_addr = 0, rd2_addr = 0;
    logic [15:0] wr_data = 0;
    logic [15:0] rd1, rd2, rd1_b0, rd2_b0, e;
    logic        busy, done, priv, conflict, busy0, done0, priv0, conflict0;
    logic [15:0] exp_q [$];
    int          total = 0, bad = 0;
    always #5 clk = ~clk;
    lc3_regfile_banked #(.BYPASS(1'b1)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .rd1_data(rd1), .rd2_data(rd2),
        .sp_swap_req(sp_swap_req), .sp_swap_to_super(sp_swap_to_super),
        .sp_swap_busy(busy), .sp_swap_done(done), .priv(priv), .wr_conflict(conflict));
    lc3_regfile_banked #(.BYPASS(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .rd1_data(rd1_b0), .rd2_data(rd2_b0),
        .sp_swap_req(sp_swap_req), .sp_swap_to_super(sp_swap_to_super),
        .sp_swap_busy(busy0), .sp_swap_done(done0), .priv(priv0), .wr_conflict(conflict0));
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
    endtask
    task automatic test_reset();
        rst = 0;
        repeat (2) tick();
        rst = 1;
        tick();
        for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h1111 * (i + 1)));
        rd1_addr = 7; exp_q.push_back(16'h8888); #1;
        e = exp_q.pop_front(); total++;
        if (rd1 !== e) begin bad++; $display("FAIL pre_reset_r7 got=%h exp=%h", rd1, e); end
        rst = 0; #1;
        for (int i = 0; i < 8; i++) begin
            rd1_addr = 3'(i); rd2_addr = 3'(7 - i);
            exp_q.push_back(16'h0); exp_q.push_back(16'h0); #1;
            e = exp_q.pop_front(); total++;
            if (rd1 !== e) begin bad++; $display("FAIL reset_rd1_r%0d got=%h exp=%h", i, rd1, e); end
            e = exp_q.pop_front(); total++;
            if (rd2 !== e) begin bad++; $display("FAIL reset_rd2_r%0d got=%h exp=%h", 7 - i, rd2, e); end
        end
        total++; if (priv !== 1'b0) begin bad++; $display("FAIL reset_priv got=%b exp=0", priv); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0 || conflict !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", done, conflict); end
        #2 rst = 1;
        tick();
    endtask
    task automatic test_bypass();
        wr_en = 1; wr_addr = 3; wr_data = 16'hBEEF; rd1_addr = 3; rd2_addr = 3;
        exp_q.push_back(16'hBEEF); exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'h0); exp_q.push_back(16'h0); #1;
        e = exp_q.pop_front(); total++; if (rd1 !== e) begin bad++; $display("FAIL bypass_rd1 got=%h exp=%h", rd1, e); end
        e = exp_q.pop_front(); total++; if (rd2 !== e) begin bad++; $display("FAIL bypass_rd2 got=%h exp=%h", rd2, e); end
        e = exp_q.pop_front(); total++; if (rd1_b0 !== e) begin bad++; $display("FAIL nobypass_rd1_old got=%h exp=%h", rd1_b0, e); end
        e = exp_q.pop_front(); total++; if (rd2_b0 !== e) begin bad++; $display("FAIL nobypass_rd2_old got=%h exp=%h", rd2_b0, e); end
        tick();
        wr_en = 0;
        exp_q.push_back(16'hBEEF); exp_q.push_back(16'hBEEF); #1;
        e = exp_q.pop_front(); total++; if (rd1_b0 !== e) begin bad++; $display("FAIL nobypass_rd1_new got=%h exp=%h", rd1_b0, e); end
        e = exp_q.pop_front(); total++; if (rd2_b0 !== e) begin bad++; $display("FAIL nobypass_rd2_new got=%h exp=%h", rd2_b0, e); end
    endtask
    task automatic test_swap_super();
        wr(6, 16'hFE00);
        rd1_addr = 6; sp_swap_req = 1; sp_swap_to_super = 1; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL swap_req_busy got=%b exp=0", busy); end
        tick();
        sp_swap_req = 0;
        exp_q.push_back(16'hFE00); exp_q.push_back(16'hFE00); exp_q.push_back(16'h3000);
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL swap_save busy/done got=%b%b exp=10", busy, done); end
        e = exp_q.pop_front(); total++; if (rd1 !== e) begin bad++; $display("FAIL swap_save_r6 got=%h exp=%h", rd1, e); end
        tick();
        total++; if (busy !== 1'b1 || priv !== 1'b0) begin bad++; $display("FAIL swap_load busy/priv got=%b%b exp=10", busy, priv); end
        e = exp_q.pop_front(); total++; if (rd1 !== e) begin bad++; $display("FAIL swap_load_r6 got=%h exp=%h", rd1, e); end
        tick();
        total++; if (busy !== 1'b0 || done !== 1'b1 || priv !== 1'b1) begin bad++; $display("FAIL swap_end busy/done/priv got=%b%b%b exp=011", busy, done, priv); end
        e = exp_q.pop_front(); total++; if (rd1 !== e) begin bad++; $display("FAIL swap_end_r6 got=%h exp=%h", rd1, e); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL swap_done_width got=%b exp=0", done); end
    endtask
    task automatic test_round_trip();
        wr(6, 16'h2FF0);
        sp_swap_req = 1; sp_swap_to_super = 0; exp_q.push_back(16'hFE00);
        tick(); sp_swap_req = 0; tick(); tick();
        e = exp_q.pop_front(); total++; if (rd1 !== e) begin bad++; $display("FAIL rt_user_r6 got=%h exp=%h", rd1, e); end
        total++; if (priv !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL rt_user priv/done got=%b%b exp=01", priv, done); end
        tick();
        sp_swap_req = 1; sp_swap_to_super = 1; exp_q.push_back(16'h2FF0);
        tick(); sp_swap_req = 0; tick(); tick();
        e = exp_q.pop_front(); total++; if (rd1 !== e) begin bad++; $display("FAIL rt_super_r6 got=%h exp=%h", rd1, e); end
        total++; if (priv !== 1'b1) begin bad++; $display("FAIL rt_super_priv got=%b exp=1", priv); end
        tick();
    endtask
    task automatic test_conflict();
        sp_swap_req = 1; sp_swap_to_super = 0;
        tick();
        sp_swap_req = 0; wr_en = 1; wr_addr = 6; wr_data = 16'h1234; #1;
        total++; if (conflict !== 1'b0) begin bad++; $display("FAIL conflict_early got=%b exp=0", conflict); end
        tick();
        total++; if (conflict !== 1'b1) begin bad++; $display("FAIL conflict_pulse got=%b exp=1", conflict); end
        wr_addr = 2; wr_data = 16'h5678;
        tick();
        wr_en = 0; rd2_addr = 2;
        exp_q.push_back(16'hFE00); exp_q.push_back(16'h5678); #1;
        total++; if (conflict !== 1'b0 || done !== 1'b1 || priv !== 1'b0) begin bad++; $display("FAIL conflict_end conflict/done/priv got=%b%b%b exp=010", conflict, done, priv); end
        e = exp_q.pop_front(); total++; if (rd1 !== e) begin bad++; $display("FAIL conflict_r6 got=%h exp=%h", rd1, e); end
        e = exp_q.pop_front(); total++; if (rd2 !== e) begin bad++; $display("FAIL conflict_r2 got=%h exp=%h", rd2, e); end
    endtask
    task automatic test_back_to_back();
        sp_swap_req = 1; sp_swap_to_super = 1; exp_q.push_back(16'h2FF0);
        tick();
        sp_swap_req = 0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        tick(); tick();
        e = exp_q.pop_front(); total++; if (rd1 !== e) begin bad++; $display("FAIL b2b_r6 got=%h exp=%h", rd1, e); end
        total++; if (priv !== 1'b1) begin bad++; $display("FAIL b2b_priv got=%b exp=1", priv); end
        tick();
        sp_swap_req = 1; sp_swap_to_super = 1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL samemode_busy got=%b exp=0", busy); end
        sp_swap_req = 0;
        tick();
        exp_q.push_back(16'h2FF0);
        total++; if (done !== 1'b0 || priv !== 1'b1) begin bad++; $display("FAIL samemode done/priv got=%b%b exp=01", done, priv); end
        e = exp_q.pop_front(); total++; if (rd1 !== e) begin bad++; $display("FAIL samemode_r6 got=%h exp=%h", rd1, e); end
    endtask
    task automatic test_mid_reset();
        sp_swap_req = 1; sp_swap_to_super = 0;
        tick();
        sp_swap_req = 0;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_in_load got=%b exp=1", busy); end
        rst = 0; exp_q.push_back(16'h0); #1;
        e = exp_q.pop_front(); total++; if (rd1 !== e) begin bad++; $display("FAIL midrst_r6 got=%h exp=%h", rd1, e); end
        total++; if (priv !== 1'b0 || busy !== 1'b0 || priv0 !== 1'b0) begin bad++; $display("FAIL midrst priv/busy/priv0 got=%b%b%b exp=000", priv, busy, priv0); end
        #2 rst = 1;
        sp_swap_req = 1; sp_swap_to_super = 0;
        tick();
        sp_swap_req = 0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_samemode_busy got=%b exp=0", busy); end
        sp_swap_req = 1; sp_swap_to_super = 1; exp_q.push_back(16'h3000);
        tick(); sp_swap_req = 0; tick(); tick();
        e = exp_q.pop_front(); total++; if (rd1 !== e) begin bad++; $display("FAIL midrst_resume_r6 got=%h exp=%h", rd1, e); end
        total++; if (priv !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL midrst_resume priv/done got=%b%b exp=11", priv, done); end
    endtask
    initial begin
        test_reset();
        test_bypass();
        test_swap_super();
        test_round_trip();
        test_conflict();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
